// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI slave slice.
//   spi_state_t : frame FSM states (IDLE, ACTIVE)
//   SPI_CPOL/CPHA : fixed mode-0 operation
//   bitcnt_w(n) : width of a counter that indexes n bits (minimum 1)
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    function automatic int unsigned bitcnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer for one asynchronous SPI pin, with edge pulses.
// Ports:
//   clk, rst_n : local clock, asynchronous active-low reset
//   din        : asynchronous pin
//   dout       : synchronized level
//   rise, fall : single-cycle pulses on synchronized 0->1 / 1->0 transitions
module spi_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~hist_q;
    assign fall = ~dout & hist_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0, MSB-first slave oversampled in the clk domain.
// Ports:
//   clk, rst_n          : system clock, asynchronous active-low reset
//   tx_data, tx_load    : word returned to the master, captured into tx_buf on tx_load
//   rx_data, rx_valid   : last complete received word, one-cycle update pulse
//   busy                : frame active (synchronized CS low)
//   frame_err           : one-cycle pulse when CS rises mid-word
//   spi_sck, spi_cs_n,
//   spi_mosi, spi_miso  : SPI pins (miso driven 0 while idle)
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_LENGTH-1:0] tx_data,
    input  logic                   tx_load,
    output logic [DATA_LENGTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   busy,
    output logic                   frame_err,
    input  logic                   spi_sck,
    input  logic                   spi_cs_n,
    input  logic                   spi_mosi,
    output logic                   spi_miso
);

    localparam int unsigned     CNT_W    = bitcnt_w(DATA_LENGTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LENGTH - 1);
    // Cycles until every synchronizer flop holds a real pin sample after reset.
    localparam int unsigned     FLUSH    = SYNC_STAGES + 1;
    localparam int unsigned     FLUSH_W  = $clog2(FLUSH + 1);

    logic sck_s, sck_rise, sck_fall;
    logic cs_n_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_sck),
        .dout (sck_s),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_cs_n),
        .dout (cs_n_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_mosi),
        .dout (mosi_s),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_s, mosi_rise, mosi_fall};

    spi_state_t             state_q, state_d;
    logic [DATA_LENGTH-1:0] tx_buf_q;
    logic [DATA_LENGTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_LENGTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_LENGTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   miso_q, miso_d;
    logic [FLUSH_W-1:0]     flush_cnt_q;
    logic                   armed_q;

    // A CS that is already low when reset releases would look like a fresh
    // fall once the synchronizer flushes; only arm after CS is seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= '0;
            armed_q     <= 1'b0;
        end else if (!armed_q) begin
            if (flush_cnt_q != FLUSH_W'(FLUSH)) begin
                flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
            end else if (cs_n_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf_q <= '0;
        end else if (tx_load) begin
            tx_buf_q <= tx_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        bit_cnt_d   = bit_cnt_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        miso_d      = miso_q;

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall && armed_q) begin
                    state_d    = ACTIVE;
                    // Same-cycle tx_load bypasses tx_buf.
                    tx_shift_d = tx_load ? tx_data : tx_buf_q;
                    bit_cnt_d  = '0;
                    miso_d     = tx_shift_d[DATA_LENGTH-1];
                end
            end
            ACTIVE: begin
                // CS rise takes priority over any coincident SCK edge.
                if (cs_rise) begin
                    state_d     = IDLE;
                    miso_d      = 1'b0;
                    bit_cnt_d   = '0;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_LENGTH-2:0], mosi_s};
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sck_fall) begin
                    // A zero count on a fall means the previous word just ended.
                    tx_shift_d = (bit_cnt_q == '0) ? tx_buf_q : (tx_shift_q << 1);
                    miso_d     = tx_shift_d[DATA_LENGTH-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign spi_miso  = miso_q;
    assign busy      = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: bench acts as an SPI mode-0 master (half period 4 clk) and keeps a
// word-level model of the slave: which tx word each frame word returns, which
// rx words must appear, and whether a frame_err is due.
module tb_spi_slave;

    localparam int unsigned DL   = 8;
    localparam int unsigned SS   = 2;
    localparam int unsigned HALF = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DL-1:0] tx_data;
    logic          tx_load;
    logic [DL-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          frame_err;
    logic          spi_sck;
    logic          spi_cs_n;
    logic          spi_mosi;
    logic          spi_miso;

    always #5 clk = ~clk;

    spi_slave #(.DATA_LENGTH(DL), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .frame_err(frame_err),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Monitor: collect rx words, frame errors and busy cycles.
    logic [DL-1:0] rx_q[$];
    int            ferr_cnt  = 0;
    int            busy_seen = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_valid) rx_q.push_back(rx_data);
            if (frame_err) ferr_cnt++;
            if (busy) busy_seen++;
        end
    end

    // Reference model state.
    logic [DL-1:0] m_buf;
    logic [DL-1:0] m_rx_data;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [DL-1:0] v);
        tx_data = v;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
        m_buf   = v;
    endtask

    task automatic sck_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            spi_sck = 1'b1;
            wait_clk(HALF);
            spi_sck = 1'b0;
            wait_clk(HALF);
        end
    endtask

    // One CS-framed transfer of nbits. load_bit >= 0 issues tx_load(load_val) during the
    // high phase of that bit; bypass issues tx_load(load_val) in the cs_fall cycle.
    task automatic run_frame(input string name, input int nbits, input logic [63:0] mosi_v,
                             input int load_bit, input bit bypass,
                             input logic [DL-1:0] load_val);
        logic [DL-1:0] word_tx;
        logic [DL-1:0] exp_w;
        logic [63:0]   got_miso;
        logic [63:0]   exp_miso;
        int            exp_words;

        rx_q.delete();
        ferr_cnt = 0;
        got_miso = '0;
        exp_miso = '0;
        word_tx  = m_buf;
        spi_cs_n = 1'b0;
        spi_mosi = mosi_v[nbits-1];
        if (bypass) begin
            // cs_fall is acted on at the third posedge after the pin change.
            wait_clk(SS);
            preload(load_val);
            word_tx = m_buf;
            wait_clk(3);
        end else begin
            wait_clk(SS + 4);
        end
        check({name, " busy"}, 64'(busy), 64'(1));

        for (int i = 0; i < nbits; i++) begin
            got_miso = {got_miso[62:0], spi_miso};
            exp_miso = {exp_miso[62:0], word_tx[DL-1-(i%DL)]};
            spi_sck  = 1'b1;
            if (i == load_bit) begin
                preload(load_val);
                wait_clk(HALF - 1);
            end else begin
                wait_clk(HALF);
            end
            spi_sck = 1'b0;
            if ((i + 1) % DL == 0) word_tx = m_buf;
            if (i + 1 < nbits) spi_mosi = mosi_v[nbits-2-i];
            wait_clk(HALF);
        end
        spi_cs_n = 1'b1;
        wait_clk(SS + 4);

        exp_words = nbits / DL;
        check({name, " rx_count"}, 64'(rx_q.size()), 64'(exp_words));
        for (int k = 0; k < exp_words; k++) begin
            exp_w     = mosi_v[nbits-1-DL*k -: DL];
            m_rx_data = exp_w;
            if (k < rx_q.size()) check({name, " rx_word"}, 64'(rx_q[k]), 64'(exp_w));
        end
        check({name, " frame_err"}, 64'(ferr_cnt), 64'((nbits % DL) != 0));
        check({name, " miso"}, got_miso, exp_miso);
        check({name, " busy_idle"}, 64'(busy), 64'(0));
        check({name, " miso_idle"}, 64'(spi_miso), 64'(0));
        check({name, " rx_data"}, 64'(rx_data), 64'(m_rx_data));
        spi_mosi = 1'b0;
    endtask

    initial begin
        int            nb;
        int            lb;
        bit            bp;
        logic [63:0]   mv;

        rst_n     = 1'b0;
        tx_data   = '0;
        tx_load   = 1'b0;
        spi_sck   = 1'b0;
        spi_cs_n  = 1'b1;
        spi_mosi  = 1'b0;
        m_buf     = '0;
        m_rx_data = '0;
        wait_clk(3);
        check("reset rx_data", 64'(rx_data), 64'(0));
        check("reset rx_valid", 64'(rx_valid), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset frame_err", 64'(frame_err), 64'(0));
        check("reset miso", 64'(spi_miso), 64'(0));
        rst_n = 1'b1;
        wait_clk(6);

        // No preload: MISO all zero; SCK with CS high does nothing.
        run_frame("nopre", 8, 64'h96, -1, 1'b0, '0);
        rx_q.delete();
        busy_seen = 0;
        sck_pulse(8);
        check("idle_sck busy", 64'(busy_seen), 64'(0));
        check("idle_sck rx", 64'(rx_q.size()), 64'(0));

        preload(8'h55);
        run_frame("basic", 8, 64'hAA, -1, 1'b0, '0);

        preload(8'hF0);
        run_frame("b2b", 16, 64'h3CC3, -1, 1'b0, '0);

        preload(8'hA5);
        run_frame("midload", 16, 64'h5A96, 3, 1'b0, 8'h0F);

        run_frame("abort", 5, 64'h17, -1, 1'b0, '0);

        preload(8'h11);
        run_frame("bypass", 8, 64'hC4, -1, 1'b1, 8'h7E);

        // Reset mid-frame with CS held low.
        preload(8'h3B);
        spi_cs_n = 1'b0;
        wait_clk(SS + 4);
        sck_pulse(4);
        rst_n = 1'b0;
        wait_clk(1);
        check("rstmid rx_data", 64'(rx_data), 64'(0));
        check("rstmid rx_valid", 64'(rx_valid), 64'(0));
        check("rstmid busy", 64'(busy), 64'(0));
        check("rstmid frame_err", 64'(frame_err), 64'(0));
        check("rstmid miso", 64'(spi_miso), 64'(0));
        m_buf     = '0;
        m_rx_data = '0;
        rx_q.delete();
        busy_seen = 0;
        ferr_cnt  = 0;
        rst_n     = 1'b1;
        wait_clk(2);
        sck_pulse(8);
        check("rstmid busy_after", 64'(busy_seen), 64'(0));
        check("rstmid rx_after", 64'(rx_q.size()), 64'(0));
        check("rstmid ferr_after", 64'(ferr_cnt), 64'(0));
        spi_cs_n = 1'b1;
        wait_clk(SS + 4);
        run_frame("rstmid_next", 8, 64'h81, -1, 1'b0, '0);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            nb = int'($urandom_range(1, 32));
            mv = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) preload(DL'($urandom));
            lb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nb - 1)) : -1;
            bp = ($urandom_range(0, 3) == 0);
            run_frame("rand", nb, mv, lb, bp, DL'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 (CPOL=0, CPHA=0), MSB-first slave that sits on the far end of the `spi_master` link. It oversamples `spi_sck`, `spi_cs_n` and `spi_mosi` in the local `clk` domain through synchronizers. It deserializes one `DATA_LENGTH`-bit word per frame into `rx_data`, and serializes a preloaded `tx_data` word onto `spi_miso`. It is the peripheral-side counterpart used to close the loop on master testbenches and in loopback systems.

## Interface
- `DATA_LENGTH`, 8, bits per word.
- `SYNC_STAGES`, 2, synchronizer flops per SPI input; must be ≥2.
- `clk` in 1: system clock; all SPI inputs are treated as asynchronous to it.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_data` in DATA_LENGTH: word to return to the master.
- `tx_load` in 1: single-cycle strobe that captures `tx_data` into `tx_buf`.
- `rx_data` out DATA_LENGTH: last complete word received.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: high while a frame is active (CS low, synchronized).
- `frame_err` out 1: one-cycle pulse when CS rises mid-word.
- `spi_sck` in 1: serial clock from master.
- `spi_cs_n` in 1: active-low chip select.
- `spi_mosi` in 1: master-out data.
- `spi_miso` out 1: slave-out data; driven 0 while idle.

## Operation
- Synchronization: each SPI input passes through `SYNC_STAGES` flops plus one history flop for edge detection. `sck_rise`, `sck_fall`, `cs_fall` and `cs_rise` are single-cycle pulses.
- FSM states are IDLE and ACTIVE.
- IDLE → ACTIVE on `cs_fall`:
  - Load `tx_shift` from `tx_buf`.
  - Clear `bit_cnt` (width `$clog2(DATA_LENGTH)`).
  - Set `busy`=1.
  - `spi_miso` = `tx_shift` MSB.
- ACTIVE, on `sck_rise`:
  - Shift `rx_shift` left, inserting synchronized MOSI.
  - Increment `bit_cnt`.
  - When `bit_cnt`==DATA_LENGTH-1: the next cycle `rx_data` = completed word and `rx_valid`=1; `bit_cnt` wraps to 0.
- ACTIVE, on `sck_fall`:
  - If `bit_cnt`==0 (word boundary), reload `tx_shift` from `tx_buf`.
  - Otherwise shift `tx_shift` left.
  - `spi_miso` always follows `tx_shift` MSB.
- Back-to-back words with CS held low are supported without limit.
- ACTIVE → IDLE on `cs_rise`:
  - `busy`=0 and `spi_miso`=0.
  - If `bit_cnt`≠0, pulse `frame_err` and discard the partial word; `rx_data` is unchanged.
- `tx_load` while ACTIVE updates `tx_buf` only. The new value takes effect at the next word boundary, never mid-word.
- `tx_load` in the same cycle as `cs_fall`: the newly loaded `tx_data` is used (bypass).
- `cs_rise` in the same cycle as an SCK edge: `cs_rise` wins and the SCK edge is ignored.
- SCK edges while IDLE are ignored.
- Reset mid-frame: everything returns to reset values immediately. The slave waits for a fresh `cs_fall`; CS already low at reset release does not start a frame.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `busy`=0, `frame_err`=0, `spi_miso`=0.
  - `tx_buf`=0, `tx_shift`=0, `rx_shift`=0, `bit_cnt`=0, FSM=IDLE.
- Input latency: an edge at a pin is acted on `SYNC_STAGES`+1 clk cycles after the first `clk` edge that samples it. That is 3–4 cycles for the default.
- `rx_valid`: exactly one cycle, one cycle after the detected final `sck_rise`.
- MISO update: registered, one cycle after the detected `sck_fall`/`cs_fall`.
- Master constraint: SCK high and low phases each ≥ `SYNC_STAGES`+2 clk cycles. CS-low to first SCK rise ≥ `SYNC_STAGES`+3 clk cycles. For the default, this means a master with `CLK_DIV` ≥ 4.
- `busy` rises/falls one cycle after the detected `cs_fall`/`cs_rise`.

## Structure
- Package `spi_pkg`:
  - `spi_state_t` enum (IDLE, ACTIVE).
  - `SPI_CPOL`/`SPI_CPHA` constants (0/0).
  - A `bitcnt_w(n)` helper function.
- Sub-module `spi_sync`: parameterized `SYNC_STAGES` synchronizer with rise/fall pulse outputs, asynchronous active-low reset, reset value taken from a parameter (1 for `cs_n`, 0 otherwise). Instantiate it three times.
- Everything else (FSM, counters, shift registers) stays in the top module.

## Test plan
- Default-parameter `spi_master`, `CLK_DIV`=4, looped to the slave:
  - **Basic transfer:** slave `tx_load` 8'h55, master sends 8'hAA → slave `rx_data`=8'hAA with one `rx_valid` pulse; master `data_out`=8'h55; `frame_err` never asserts.
- Bench-driven pins for the remaining cases:
  - **Back-to-back words:** CS held low for 16 bits, MOSI 8'h3C then 8'hC3, `tx_buf`=8'hF0 → two `rx_valid` pulses with 8'h3C then 8'hC3; MISO shows F0 twice.
  - **`tx_load` mid-word:** 8'h0F loaded during bit 3 of word 1 (`tx_buf`=8'hA5) → word 1 MISO=8'hA5, word 2 MISO=8'h0F.
  - **Aborted frame:** CS rises after 5 SCK rises → single `frame_err` pulse, no `rx_valid`, `rx_data` unchanged, `busy`=0, `spi_miso`=0.
  - **Reset mid-frame:** `rst_n` pulsed low after 4 bits, CS held low → all outputs 0 and no `rx_valid`. The next CS high→low frame with 8'h81 yields `rx_data`=8'h81.
  - **No preload:** no `tx_load` after reset → MISO stays 0 for the whole frame; SCK toggling with CS high produces no `busy` or `rx_valid`.
